alu_bist: RTL and testbench

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist_pkg.sv | 19 +
 rtl/alu_bist_lfsr32_galois.sv | 35 +++
 rtl/alu_bist.sv | 159 +++++++++++++++
 tb/tb_alu_bist.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST: LFSR/MISR polynomial, FSM encoding, opcode width.
package alu_bist_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int          OP_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Right-shifting Galois step: feed the LSB back through the tap mask.
  function automatic logic [31:0] galois_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/alu_bist_lfsr32_galois.sv
// 32-bit Galois LFSR pattern source; load has priority over enable.
module lfsr32_galois
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (enable) begin
      state_d = galois_step(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self test: drives LFSR operand vectors with a rolling opcode and
// compacts the ALU responses into a MISR signature.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | one vector issued per cycle
// ST_DRAIN | one extra cycle to absorb the last captured response
// ST_DONE  | signature/pass valid and held; start re-arms a run
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED_A     = 32'h0000_0005,
  parameter logic [31:0] SEED_B     = 32'h0000_0003,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000,
  parameter int          CNT_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [OP_W-1:0]  ALUControl,
  input  logic [31:0]      Result,
  input  logic [3:0]       ALUFlags,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
  output logic             pass
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [31:0]      misr_q, misr_d;
  logic [31:0]      resp_q, resp_d;
  logic             cap_q, cap_d;

  logic             lfsr_load;
  logic             lfsr_en;
  logic [31:0]      lfsr_a;
  logic [31:0]      lfsr_b;
  logic             accept;
  logic             last_vec;
  logic [CNT_W-1:0] cnt_inc;

  lfsr32_galois u_lfsr_a (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (SEED_A),
    .state  (lfsr_a)
  );

  lfsr32_galois u_lfsr_b (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (SEED_B),
    .state  (lfsr_b)
  );

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_vec = (cnt_q == (nvec_q - CNT_ONE));
  assign cnt_inc  = cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nvec_d    = nvec_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    resp_d    = resp_q;
    cap_d     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    // The response captured on the previous cycle is folded in one cycle later.
    misr_d    = cap_q ? (galois_step(misr_q) ^ resp_q) : misr_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          nvec_d    = num_vectors;
          cnt_d     = '0;
          misr_d    = 32'h0000_0000;
          lfsr_load = 1'b1;
          if (num_vectors != '0) begin
            state_d = ST_RUN;
            a_d     = SEED_A;
            b_d     = SEED_B;
            op_d    = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        cap_d   = 1'b1;
        resp_d  = Result ^ {28'b0, ALUFlags};
        lfsr_en = 1'b1;
        if (last_vec) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_inc;
          a_d   = galois_step(lfsr_a);
          b_d   = galois_step(lfsr_b);
          op_d  = cnt_inc[OP_W-1:0];
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nvec_q  <= '0;
      a_q     <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
      op_q    <= '0;
      misr_q  <= 32'h0000_0000;
      resp_q  <= 32'h0000_0000;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      misr_q  <= misr_d;
      resp_q  <= resp_d;
      cap_q   <= cap_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign ALUControl = op_q;
  assign signature  = misr_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign pass       = (state_q == ST_DONE) && (misr_q == GOLDEN_SIG);

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: reference ALU and signature model in the bench,
// randomized run lengths and ignored start pulses, reset mid-run and fault injection.
module tb_alu_bist;

  localparam int          CNT_W  = 7;
  localparam logic [31:0] SEED_A = 32'h0000_0005;
  localparam logic [31:0] SEED_B = 32'h0000_0003;
  localparam logic [31:0] GOLDEN = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [31:0]      A, B, Result, signature;
  logic [3:0]       ALUControl, ALUFlags;
  logic             busy, done, pass;

  logic             fault_en;
  logic [31:0]      fault_a, fault_b;
  logic [35:0]      alu_out;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] sig; logic pass; int n; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; } vec_t;
  exp_t exp_q[$];
  vec_t vec_q[$];

  logic [31:0] last_a, last_b;

  always #5 clk = ~clk;

  alu_bist #(.SEED_A(SEED_A), .SEED_B(SEED_B), .GOLDEN_SIG(GOLDEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .A(A), .B(B), .ALUControl(ALUControl), .Result(Result), .ALUFlags(ALUFlags),
    .busy(busy), .done(done), .signature(signature), .pass(pass)
  );

  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1:  begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = {31'b0, $signed(a) < $signed(b)};
      4'd9:  r = {31'b0, a < b};
      4'd10: r = ~(a & b);
      4'd11: r = ~(a | b);
      4'd12: r = ~(a ^ b);
      4'd13: r = a;
      4'd14: r = b;
      default: r = a + 32'd1;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic [31:0] gstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign alu_out  = alu_ref(A, B, ALUControl);
  assign Result   = alu_out[31:0] ^ {31'b0, (fault_en && (A == fault_a) && (B == fault_b))};
  assign ALUFlags = alu_out[35:32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Signature of an n-vector run from the seeds, optionally with one corrupted Result bit 0.
  task automatic model(input int n, input int fk, input bit push, output logic [31:0] sig);
    logic [31:0] a, b, r, misr;
    logic [35:0] o;
    vec_t        v;
    a = SEED_A;
    b = SEED_B;
    misr = 32'd0;
    for (int i = 0; i < n; i++) begin
      o = alu_ref(a, b, 4'(i % 16));
      r = o[31:0];
      if (i == fk) begin
        r = r ^ 32'd1;
        if (push) begin fault_a = a; fault_b = b; fault_en = 1'b1; end
      end
      misr = gstep(misr) ^ (r ^ {28'b0, o[35:32]});
      if (push) begin
        v.a = a; v.b = b; v.op = 4'(i % 16);
        vec_q.push_back(v);
        last_a = a; last_b = b;
      end
      a = gstep(a);
      b = gstep(b);
    end
    sig = misr;
    if (push) exp_q.push_back('{sig: misr, pass: (misr == GOLDEN), n: n});
  endtask

  // Monitor: checks each issued vector and each completed run against the queues.
  int   bcnt = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    vec_t v;
    exp_t e;
    if (rst) begin
      bcnt = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) begin
        bcnt++;
        if (exp_q.size() > 0 && bcnt <= exp_q[0].n) begin
          if (vec_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL vec_queue_empty: got vector with no expectation at busy cycle %0d", bcnt);
          end else begin
            v = vec_q.pop_front();
            chk("vec_A", A, v.a);
            chk("vec_B", B, v.b);
            chk("vec_op", 32'(ALUControl), 32'(v.op));
          end
        end
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          chk("signature", signature, e.sig);
          chk("pass", 32'(pass), 32'(e.pass));
          chk("busy_cycles", bcnt, (e.n == 0) ? 0 : e.n + 1);
        end
        bcnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic run(input int n, input int fk, input bit poke, output logic [31:0] sig);
    int cyc, pk;
    model(n, fk, 1'b1, sig);
    pk = (poke && n >= 3) ? int'($urandom_range(1, n - 1)) : -1;
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < n + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == pk) begin
        start = 1'b1;
        num_vectors = CNT_W'($urandom_range(0, 127));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done for n=%0d", cyc, n);
      exp_q.delete();
      vec_q.delete();
    end else begin
      chk("done_latency", cyc, (n == 0) ? 1 : n + 2);
      chk("hold_A", A, last_a);
      chk("hold_B", B, last_b);
      repeat (2) @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
      chk("sig_hold", signature, sig);
    end
    fault_en = 1'b0;
  endtask

  initial begin
    logic [31:0] s, clean;
    int          k;
    rst = 1'b1; start = 1'b0; num_vectors = '0; fault_en = 1'b0;
    fault_a = '0; fault_b = '0; last_a = '0; last_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_A", A, 0); chk("rst_B", B, 0); chk("rst_op", 32'(ALUControl), 0);
    chk("rst_sig", signature, 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0); chk("rst_pass", 32'(pass), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    run(0, -1, 1'b0, s);
    chk("zero_vec_sig", signature, 32'd0);
    run(1, -1, 1'b0, s);
    chk("one_vec_sig", signature, 32'h0000_0008);
    run(32, -1, 1'b0, s);
    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(2, 40)), -1, 1'($urandom_range(0, 1)), s);
    end
    run(127, -1, 1'b1, s);

    model(20, -1, 1'b0, clean);
    run(20, 7, 1'b0, s);
    chk("fault_sig_differs", 32'(signature != clean), 32'd1);
    chk("fault_not_golden", 32'(signature != GOLDEN), 32'd1);
    chk("fault_pass_low", 32'(pass), 32'd0);

    // Reset in the middle of a 100-vector run, then rerun it cleanly.
    model(100, -1, 1'b1, clean);
    start = 1'b1; num_vectors = CNT_W'(100);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (ALUControl != 4'd10 && k < 50) begin @(negedge clk); k++; end
    chk("reached_vec10", 32'(ALUControl), 32'd10);
    #1;
    exp_q.delete(); vec_q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_A", A, 0); chk("midrst_B", B, 0); chk("midrst_op", 32'(ALUControl), 0);
    chk("midrst_sig", signature, 0); chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0); chk("midrst_pass", 32'(pass), 0);
    last_a = '0; last_b = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    run(100, -1, 1'b1, s);
    chk("rerun_sig_matches", signature, clean);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size() + vec_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
